// File: rtl/ham_decode_8_4_pipe.sv
// Two-stage (8,4) Hamming decoder with valid/ready flow control.
// Stage 1 registers the codeword and its syndrome; stage 2 registers the
// corrected data and error flags. Optional saturating error counters are
// built only when HAM_DECODE_CNT_EN is defined; otherwise the counter ports
// read zero and cnt_clr_i is ignored.
module ham_decode_8_4_pipe #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             cw_valid_i,
   input  logic [7:0]       cw_i,
   output logic             cw_ready_o,
   output logic             dat_valid_o,
   output logic [3:0]       dat_o,
   output logic             sbe_o,
   output logic             dbe_o,
   output logic [3:0]       syn_o,
   input  logic             dat_ready_i,
   input  logic             cnt_clr_i,
   output logic [CNT_W-1:0] sbe_cnt_o,
   output logic [CNT_W-1:0] dbe_cnt_o
);

   // Stage 1 state
   logic       s1_valid_q;
   logic [7:0] s1_cw_q;
   logic [3:0] s1_syn_q;

   // Stage 2 state
   logic       s2_valid_q;
   logic [3:0] dat_q;
   logic       sbe_q;
   logic       dbe_q;
   logic [3:0] syn_q;

   logic [3:0] exp_chk;
   logic [3:0] in_syn;
   logic       s2_advance;
   logic       s1_advance;
   logic       cw_ready;
   logic [3:0] fix_dat;
   logic       fix_sbe;
   logic       fix_dbe;

   // Expected check bits from received data and the resulting syndrome
   always_comb begin
      exp_chk[3] = cw_i[3] ^ cw_i[2] ^ cw_i[0];
      exp_chk[2] = cw_i[2] ^ cw_i[1] ^ cw_i[0];
      exp_chk[1] = cw_i[3] ^ cw_i[2] ^ cw_i[1];
      exp_chk[0] = cw_i[3] ^ cw_i[1] ^ cw_i[0];
      in_syn     = exp_chk ^ cw_i[7:4];
   end

   // Handshake: stage 2 drains when empty or accepted; stage 1 follows it
   always_comb begin
      s2_advance = ~s2_valid_q | dat_ready_i;
      s1_advance = s1_valid_q & s2_advance;
      cw_ready   = ~s1_valid_q | s1_advance;
   end

   // Stage 1 register: capture codeword and syndrome whenever it can accept
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_valid_q <= 1'b0;
         s1_cw_q    <= 8'h00;
         s1_syn_q   <= 4'h0;
      end else if (cw_ready) begin
         s1_valid_q <= cw_valid_i;
         s1_cw_q    <= cw_i;
         s1_syn_q   <= in_syn;
      end
   end

   // Syndrome classification: data column -> flip, one-hot -> check-bit hit
   always_comb begin
      fix_dat = s1_cw_q[3:0];
      fix_sbe = 1'b0;
      fix_dbe = 1'b0;
      case (s1_syn_q)
         4'b0000: ;
         4'b1011: begin fix_dat[3] = ~s1_cw_q[3]; fix_sbe = 1'b1; end
         4'b1110: begin fix_dat[2] = ~s1_cw_q[2]; fix_sbe = 1'b1; end
         4'b0111: begin fix_dat[1] = ~s1_cw_q[1]; fix_sbe = 1'b1; end
         4'b1101: begin fix_dat[0] = ~s1_cw_q[0]; fix_sbe = 1'b1; end
         4'b0001, 4'b0010, 4'b0100, 4'b1000: fix_sbe = 1'b1;
         default: fix_dbe = 1'b1;
      endcase
   end

   // Stage 2 register: holds while a presented result is not accepted
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s2_valid_q <= 1'b0;
         dat_q      <= 4'h0;
         sbe_q      <= 1'b0;
         dbe_q      <= 1'b0;
         syn_q      <= 4'h0;
      end else if (s2_advance) begin
         s2_valid_q <= s1_valid_q;
         dat_q      <= fix_dat;
         sbe_q      <= fix_sbe;
         dbe_q      <= fix_dbe;
         syn_q      <= s1_syn_q;
      end
   end

`ifdef HAM_DECODE_CNT_EN
   logic [CNT_W-1:0] sbe_cnt_q;
   logic [CNT_W-1:0] dbe_cnt_q;
   logic             xfer;
   logic [CNT_W-1:0] cnt_one;

   assign xfer    = s2_valid_q & dat_ready_i;
   assign cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

   // Saturating error counters; clear takes priority over increment
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sbe_cnt_q <= '0;
         dbe_cnt_q <= '0;
      end else if (cnt_clr_i) begin
         sbe_cnt_q <= '0;
         dbe_cnt_q <= '0;
      end else begin
         if (xfer && sbe_q && (sbe_cnt_q != '1)) sbe_cnt_q <= sbe_cnt_q + cnt_one;
         if (xfer && dbe_q && (dbe_cnt_q != '1)) dbe_cnt_q <= dbe_cnt_q + cnt_one;
      end
   end

   assign sbe_cnt_o = sbe_cnt_q;
   assign dbe_cnt_o = dbe_cnt_q;
`else
   logic unused_cnt_clr;
   assign unused_cnt_clr = cnt_clr_i;
   assign sbe_cnt_o      = '0;
   assign dbe_cnt_o      = '0;
`endif

   assign cw_ready_o  = cw_ready;
   assign dat_valid_o = s2_valid_q;
   assign dat_o       = dat_q;
   assign sbe_o       = sbe_q;
   assign dbe_o       = dbe_q;
   assign syn_o       = syn_q;

endmodule

// File: tb/tb_ham_decode_8_4_pipe.sv
// Self-checking bench for ham_decode_8_4_pipe. Reference decoding is a
// nearest-codeword search; counter expectations follow HAM_DECODE_CNT_EN.
module tb_ham_decode_8_4_pipe;

   localparam int unsigned CW      = 4;
   localparam int          CNT_MAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cw_valid = 1'b0;
   logic [7:0]    cw = 8'h00;
   logic          cw_ready;
   logic          dat_valid;
   logic [3:0]    dat;
   logic          sbe;
   logic          dbe;
   logic [3:0]    syn;
   logic          dat_ready = 1'b0;
   logic          cnt_clr = 1'b0;
   logic [CW-1:0] sbe_cnt;
   logic [CW-1:0] dbe_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   int cnt_s_m  = 0;
   int cnt_d_m  = 0;
   logic [9:0] exp_q[$];

   ham_decode_8_4_pipe #(.CNT_W(CW)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .cw_valid_i  (cw_valid),
      .cw_i        (cw),
      .cw_ready_o  (cw_ready),
      .dat_valid_o (dat_valid),
      .dat_o       (dat),
      .sbe_o       (sbe),
      .dbe_o       (dbe),
      .syn_o       (syn),
      .dat_ready_i (dat_ready),
      .cnt_clr_i   (cnt_clr),
      .sbe_cnt_o   (sbe_cnt),
      .dbe_cnt_o   (dbe_cnt)
   );

   always #5 clk = ~clk;

   // Check bits as parities over the data bits each one covers
   function automatic logic [3:0] enc(input logic [3:0] d);
      logic [3:0] e;
      e[3] = ^(d & 4'b1101);
      e[2] = ^(d & 4'b0111);
      e[1] = ^(d & 4'b1110);
      e[0] = ^(d & 4'b1011);
      return e;
   endfunction

   // Returns {data, sbe, dbe, syn}: correct to a codeword one bit away if any
   function automatic logic [9:0] ref_decode(input logic [7:0] c);
      logic [3:0] s;
      logic [3:0] d;
      logic [7:0] f;
      logic       found;
      s     = enc(c[3:0]) ^ c[7:4];
      d     = c[3:0];
      found = 1'b0;
      if (s != 4'h0) begin
         for (int i = 0; i < 8; i++) begin
            f = c ^ (8'h01 << i);
            if (enc(f[3:0]) == f[7:4]) begin
               found = 1'b1;
               d     = f[3:0];
            end
         end
         return {d, found, ~found, s};
      end
      return {d, 1'b0, 1'b0, s};
   endfunction

   function automatic int exp_cnt(input int m);
`ifdef HAM_DECODE_CNT_EN
      return m;
`else
      return 0 * m;
`endif
   endfunction

   task automatic test_reset();
      #3;
      n_checks += 6;
      if (cw_ready !== 1'b1) begin n_fail++; $display("FAIL rst_cw_ready got %b want 1", cw_ready); end
      if (dat_valid !== 1'b0) begin n_fail++; $display("FAIL rst_dat_valid got %b want 0", dat_valid); end
      if (dat !== 4'h0) begin n_fail++; $display("FAIL rst_dat got %h want 0", dat); end
      if ({sbe, dbe} !== 2'b00) begin n_fail++; $display("FAIL rst_flags got %b want 00", {sbe, dbe}); end
      if (syn !== 4'h0) begin n_fail++; $display("FAIL rst_syn got %h want 0", syn); end
      if ({sbe_cnt, dbe_cnt} !== '0) begin
         n_fail++; $display("FAIL rst_cnt got %h/%h want 0/0", sbe_cnt, dbe_cnt);
      end
      @(negedge clk);
      @(negedge clk);
      // Release and present a word immediately: it must be taken on the first edge
      rst_n = 1'b1; cw_valid = 1'b1; cw = 8'h8A; dat_ready = 1'b1;
      #1;
      n_checks++;
      if (cw_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready got %b want 1", cw_ready); end
      @(posedge clk); #1 cw_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (dat_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_early got %b want 0", dat_valid); end
      @(negedge clk);
      n_checks++;
      if ({dat_valid, dat, sbe, dbe, syn} !== {1'b1, 4'hA, 1'b1, 1'b0, 4'b0100}) begin
         n_fail++;
         $display("FAIL post_rst_word got v%b d%h s%b d%b y%b want v1 dA s1 d0 y0100",
                  dat_valid, dat, sbe, dbe, syn);
      end
   endtask

   task automatic test_vectors();
      logic [7:0] vec [4];
      logic [9:0] want [4];
      vec[0] = 8'hCA; want[0] = {4'hA, 1'b0, 1'b0, 4'b0000};
      vec[1] = 8'hC8; want[1] = {4'hA, 1'b1, 1'b0, 4'b0111};
      vec[2] = 8'h8A; want[2] = {4'hA, 1'b1, 1'b0, 4'b0100};
      vec[3] = 8'hC3; want[3] = {4'h3, 1'b0, 1'b1, 4'b0110};
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1 cw_valid = 1'b1; cw = vec[i]; dat_ready = 1'b1;
         @(posedge clk); #1 cw_valid = 1'b0;
         @(negedge clk);
         n_checks++;
         if (dat_valid !== 1'b0) begin n_fail++; $display("FAIL vec%0d_latency got %b want 0", i, dat_valid); end
         @(negedge clk);
         n_checks += 2;
         if (dat_valid !== 1'b1) begin n_fail++; $display("FAIL vec%0d_valid got %b want 1", i, dat_valid); end
         if ({dat, sbe, dbe, syn} !== want[i]) begin
            n_fail++; $display("FAIL vec%0d_result got %b want %b", i, {dat, sbe, dbe, syn}, want[i]);
         end
      end
   endtask

   // mode 0: random valid/ready/data; 1: 8-word stall pattern; 2: constant C8 stream
   task automatic test_stream(input int n_words, input int mode, input int max_cycles);
      int         sent = 0;
      int         got = 0;
      int         cyc = 0;
      logic       stalled_prev = 1'b0;
      logic [9:0] prev_out = '0;
      logic [9:0] e;
      @(posedge clk); #1 cnt_clr = 1'b1; cw_valid = 1'b0; dat_ready = 1'b1;
      @(posedge clk); #1 cnt_clr = 1'b0;
      cnt_s_m = 0; cnt_d_m = 0;
      exp_q.delete();
      while (got < n_words && cyc < max_cycles) begin
         if (cyc != 0) begin @(posedge clk); #1; end
         if (sent < n_words) begin
            cw_valid = (mode == 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
            cw       = (mode == 2) ? 8'hC8 : 8'($urandom);
         end else begin
            cw_valid = 1'b0;
         end
         case (mode)
            0:       dat_ready = ($urandom_range(0, 3) != 0);
            1:       dat_ready = !(cyc >= 3 && cyc < 6);
            default: dat_ready = 1'b1;
         endcase
         @(negedge clk);
         n_checks += 2;
         if (sbe_cnt !== CW'(exp_cnt(cnt_s_m))) begin
            n_fail++; $display("FAIL stream_sbe_cnt got %0d want %0d", sbe_cnt, exp_cnt(cnt_s_m));
         end
         if (dbe_cnt !== CW'(exp_cnt(cnt_d_m))) begin
            n_fail++; $display("FAIL stream_dbe_cnt got %0d want %0d", dbe_cnt, exp_cnt(cnt_d_m));
         end
         if (stalled_prev) begin
            n_checks++;
            if ({dat_valid, dat, sbe, dbe, syn} !== {1'b1, prev_out}) begin
               n_fail++;
               $display("FAIL stall_hold got v%b %b want v1 %b", dat_valid, {dat, sbe, dbe, syn}, prev_out);
            end
         end
         if (mode == 1 && cyc >= 3 && cyc < 6) begin
            n_checks++;
            if (cw_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready cyc%0d got %b want 0", cyc, cw_ready); end
         end
         if (dat_valid) begin
            n_checks++;
            if (sbe && dbe) begin n_fail++; $display("FAIL flags_excl got sbe1 dbe1 want not both"); end
         end
         if (dat_valid && dat_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL stream_extra got %b want no word", {dat, sbe, dbe, syn});
            end else begin
               e = exp_q.pop_front();
               if ({dat, sbe, dbe, syn} !== e) begin
                  n_fail++; $display("FAIL stream_word%0d got %b want %b", got, {dat, sbe, dbe, syn}, e);
               end
               if (e[5] && cnt_s_m < CNT_MAX) cnt_s_m++;
               if (e[4] && cnt_d_m < CNT_MAX) cnt_d_m++;
            end
            got++;
         end
         if (cw_valid && cw_ready) begin
            exp_q.push_back(ref_decode(cw));
            sent++;
         end
         stalled_prev = dat_valid & ~dat_ready;
         prev_out     = {dat, sbe, dbe, syn};
         cyc++;
      end
      n_checks += 2;
      if (got != n_words) begin n_fail++; $display("FAIL stream_count got %0d want %0d", got, n_words); end
      if (exp_q.size() != 0) begin n_fail++; $display("FAIL stream_leftover got %0d want 0", exp_q.size()); end
      @(posedge clk); #1 cw_valid = 1'b0;
   endtask

   task automatic test_back_to_back();
      test_stream(8, 1, 100);
   endtask

   task automatic test_counters();
      test_stream(20, 2, 200);
      @(negedge clk);
      n_checks += 2;
      if (sbe_cnt !== CW'(exp_cnt(CNT_MAX))) begin
         n_fail++; $display("FAIL cnt_sat got %0d want %0d", sbe_cnt, exp_cnt(CNT_MAX));
      end
      if (dbe_cnt !== '0) begin n_fail++; $display("FAIL cnt_dbe_idle got %0d want 0", dbe_cnt); end
      // Clear in the same cycle as an sbe transfer
      @(posedge clk); #1 cw_valid = 1'b1; cw = 8'hC8; dat_ready = 1'b1;
      @(posedge clk); #1 cw_valid = 1'b0;
      @(posedge clk); #1 cnt_clr = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({dat_valid, sbe} !== 2'b11) begin n_fail++; $display("FAIL clr_pre got %b want 11", {dat_valid, sbe}); end
      @(posedge clk); #1 cnt_clr = 1'b0;
      @(negedge clk);
      n_checks++;
      if (sbe_cnt !== '0) begin n_fail++; $display("FAIL clr_wins got %0d want 0", sbe_cnt); end
      @(posedge clk); #1 cw_valid = 1'b1; cw = 8'hC3;
      @(posedge clk); #1 cw_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      n_checks += 2;
      if (dbe_cnt !== CW'(exp_cnt(1))) begin n_fail++; $display("FAIL cnt_dbe got %0d want %0d", dbe_cnt, exp_cnt(1)); end
      if (sbe_cnt !== '0) begin n_fail++; $display("FAIL cnt_sbe_after got %0d want 0", sbe_cnt); end
   endtask

   task automatic test_reset_mid();
      @(posedge clk); #1 dat_ready = 1'b0; cw_valid = 1'b1; cw = 8'hC8;
      @(posedge clk); #1 cw = 8'hC3;
      @(posedge clk); #1 cw_valid = 1'b0;
      @(negedge clk);
      n_checks += 2;
      if (dat_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid got %b want 1", dat_valid); end
      if (cw_ready !== 1'b0) begin n_fail++; $display("FAIL mid_pre_full got %b want 0", cw_ready); end
      #2 rst_n = 1'b0;
      #1;
      n_checks += 3;
      if (dat_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got %b want 0", dat_valid); end
      if (cw_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ready got %b want 1", cw_ready); end
      if ({sbe_cnt, dbe_cnt} !== '0) begin
         n_fail++; $display("FAIL mid_rst_cnt got %h/%h want 0/0", sbe_cnt, dbe_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1; dat_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_checks++;
         if (dat_valid !== 1'b0) begin n_fail++; $display("FAIL mid_post%0d got %b want 0", i, dat_valid); end
      end
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_stream(400, 0, 5000);
      test_back_to_back();
      test_counters();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ham_decode_8_4_pipe.md
HAM_DECODE_8_4_PIPE -- requirements
Module: ham_decode_8_4_pipe

Interface
REQ-001 SHALL have parameter CNT_W, default 16, giving the width of each error counter (legal range 4..32).
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port cw_valid_i, input, 1 bit: codeword present.
REQ-005 SHALL have port cw_i, input, 8 bits: received codeword, {check[3:0], data[3:0]}.
REQ-006 SHALL have port cw_ready_o, output, 1 bit: codeword accepted when high with cw_valid_i.
REQ-007 SHALL have port dat_valid_o, output, 1 bit: decoded result present.
REQ-008 SHALL have port dat_o, output, 4 bits: corrected data.
REQ-009 SHALL have port sbe_o, output, 1 bit: single-bit error detected and corrected.
REQ-010 SHALL have port dbe_o, output, 1 bit: uncorrectable error detected.
REQ-011 SHALL have port syn_o, output, 4 bits: syndrome of the presented result.
REQ-012 SHALL have port dat_ready_i, input, 1 bit: downstream accepts the result.
REQ-013 SHALL have port cnt_clr_i, input, 1 bit: synchronous clear of both counters.
REQ-014 SHALL have ports sbe_cnt_o and dbe_cnt_o, outputs, CNT_W bits each: saturating error counts.

Function
REQ-015 SHALL compute expected check bits from received data with the team (8,4) key: e3=d3^d2^d0, e2=d2^d1^d0, e1=d3^d2^d1, e0=d3^d1^d0.
REQ-016 SHALL form syndrome s = expected ^ received check[3:0].
REQ-017 SHALL classify: s=0 -> clean; s equal to a data column (d3:1011, d2:1110, d1:0111, d0:1101) -> flip that data bit, sbe=1; s one-hot -> check-bit error, data unchanged, sbe=1; any other value (weight 2 or 4) -> dbe=1, data passed uncorrected.
REQ-018 SHALL never assert sbe_o and dbe_o together.
REQ-019 SHALL be a two-stage pipeline: stage 1 registers codeword and syndrome; stage 2 registers dat_o, sbe_o, dbe_o and syn_o.
REQ-020 SHALL present the result of a codeword accepted in cycle N in cycle N+2 when dat_ready_i is held high.
REQ-021 SHALL sustain one codeword per cycle with no bubbles while dat_ready_i is high.
REQ-022 SHALL hold stage 2 stable while dat_valid_o=1 and dat_ready_i=0.
REQ-023 SHALL advance stage 1 only when stage 2 is empty or draining, and SHALL drive cw_ready_o = ~s1_valid | s1_advance (combinational, no dependence on cw_valid_i).
REQ-024 SHALL keep all stage 2 outputs stable, and SHALL not lose or duplicate words, under any valid/ready interleaving.
REQ-025 SHALL leave dat_o, sbe_o, dbe_o and syn_o don't-care while dat_valid_o=0; the bench ignores them.

Reset
REQ-026 SHALL, while rst_ni=0, force stage valids low, cw_ready_o=1, dat_valid_o=0, dat_o=0, sbe_o=0, dbe_o=0, syn_o=0 and both counters 0.
REQ-027 SHALL discard in-flight words when reset asserts mid-stream, with no result emitted after release.
REQ-028 SHALL accept a codeword in the first clock after rst_ni deasserts.

Configuration
REQ-029 SHALL gate the error counters with macro HAM_DECODE_CNT_EN.
REQ-030 With HAM_DECODE_CNT_EN defined, SHALL increment sbe_cnt_o/dbe_cnt_o by one per result transferred (dat_valid_o & dat_ready_i) with sbe_o/dbe_o set, and SHALL saturate each counter at all-ones.
REQ-031 With HAM_DECODE_CNT_EN defined, cnt_clr_i SHALL win over a same-cycle increment, and the counter SHALL read 0 next cycle.
REQ-032 Without HAM_DECODE_CNT_EN, SHALL keep the ports present, tie sbe_cnt_o and dbe_cnt_o to 0, ignore cnt_clr_i, and instantiate no counter flops.

Verification
REQ-033 Clean: cw_i=8'hCA, ready high -> 2 cycles later dat_o=4'hA, syn_o=0, sbe_o=0, dbe_o=0.
REQ-034 Data error: cw_i=8'hC8 -> dat_o=4'hA, syn_o=4'b0111, sbe_o=1; cw_i=8'h8A (check bit 2 flipped) -> dat_o=4'hA, syn_o=4'b0100, sbe_o=1.
REQ-035 Double error: cw_i=8'hC3 -> syn_o=4'b0110, dbe_o=1, sbe_o=0, dat_o=4'h3.
REQ-036 Backpressure: stream 8 words, dat_ready_i low for 3 cycles mid-stream -> cw_ready_o low once both stages are full; output order preserved; no loss or duplication; outputs stable while stalled.
REQ-037 Counters (CNT_W=4, macro on): 20 sbe words -> sbe_cnt_o=4'hF; cnt_clr_i together with an sbe transfer -> next cycle 0.
REQ-038 Reset mid-stream with both stages valid -> dat_valid_o=0 immediately and stays 0 until new input; counters 0.
